score_bcd_accum: RTL and testbench

SCORE_BCD_ACCUM -- requirements
Module: score_bcd_accum

---
 rtl/score_bcd_accum.sv | 170 +++++++++++++++++
 tb/tb_score_bcd_accum.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_accum.sv
// Packed-BCD score accumulator: converts an 8-bit binary increment to BCD by
// shift-add-3, then ripples it into the score one decimal digit per cycle.
module score_bcd_accum #(
    parameter int DIGITS = 6
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                clear,
    input  logic                add_valid,
    input  logic [7:0]          add_value,
    output logic                add_ready,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic                overflow
);

    localparam int SW = 4 * DIGITS;
    localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};
    localparam logic [3:0] CONV_LAST = 4'd7;
    localparam logic [3:0] ADD_LAST = 4'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ADD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    bin_q, bin_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [SW-1:0] work_q, work_d;
    logic          carry_q, carry_d;
    logic [SW-1:0] score_q, score_d;
    logic          ovf_q, ovf_d;
    logic [SW-1:0] op_ext;
    logic [4:0]    sum;

    // One double-dabble iteration: bias digits >= 5 by 3, then shift the
    // next binary bit into the BCD field.
    function automatic logic [19:0] dabble_step(input logic [11:0] bcd,
                                                input logic [7:0]  bin);
        logic [11:0] adj;
        adj = '0;
        for (int k = 0; k < 3; k++) begin
            adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3
                                                      : bcd[4*k +: 4];
        end
        return {adj, bin} << 1;
    endfunction

    // Decimal digit add: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9) begin
            s = s - 5'd10;
            return {1'b1, s[3:0]};
        end
        return {1'b0, s[3:0]};
    endfunction

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (add_valid) state_d = CONV;
            CONV:    if (cnt_q == CONV_LAST) state_d = ADD;
            ADD:     if (cnt_q == ADD_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        add_ready = (state_q == IDLE);
        score_bcd = score_q;
        overflow  = ovf_q;
    end

    always_comb begin
        op_ext = SW'(bcd_q);
    end

    always_comb begin
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        work_d  = work_q;
        carry_d = carry_q;
        score_d = score_q;
        ovf_d   = ovf_q;
        sum     = '0;
        case (state_q)
            IDLE: begin
                if (add_valid) begin
                    bin_d   = add_value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    work_d  = '0;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = dabble_step(bcd_q, bin_q);
                cnt_d = (cnt_q == CONV_LAST) ? 4'd0 : cnt_q + 4'd1;
            end
            ADD: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (cnt_q == 4'(i)) begin
                        sum = bcd_digit_add(score_q[4*i +: 4], op_ext[4*i +: 4], carry_q);
                        work_d[4*i +: 4] = sum[3:0];
                        carry_d = sum[4];
                    end
                end
                // Score is only ever written here, as a whole, so no partial sum is visible.
                if (cnt_q == ADD_LAST) begin
                    score_d = sum[4] ? NINES : work_d;
                    ovf_d   = ovf_q | sum[4];
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        if (clear) begin
            cnt_d   = '0;
            bin_d   = '0;
            bcd_d   = '0;
            work_d  = '0;
            carry_d = 1'b0;
            score_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            score_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            score_q <= score_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_score_bcd_accum.sv
// Directed bench for score_bcd_accum at DIGITS=6.
module tb_score_bcd_accum;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        clear;
    logic        add_valid;
    logic [7:0]  add_value;
    logic        add_ready;
    logic [23:0] score_bcd;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    score_bcd_accum #(.DIGITS(6)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .clear(clear),
        .add_valid(add_valid),
        .add_value(add_value),
        .add_ready(add_ready),
        .score_bcd(score_bcd),
        .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!add_ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(add_ready), 32'd1);
    endtask

    // One handshake, then watch the busy window: length, score stability, result.
    task automatic do_add(input string tag, input logic [7:0] v,
                          input logic [23:0] exp_score, input logic exp_ovf);
        logic [23:0] s0;
        int busy;
        int changes;
        wait_ready(tag);
        s0 = score_bcd;
        add_valid = 1'b1;
        add_value = v;
        tick();
        add_valid = 1'b0;
        add_value = ~v;
        busy = 0;
        changes = 0;
        while (!add_ready && busy < 60) begin
            if (score_bcd !== s0) changes++;
            busy++;
            tick();
        end
        check({tag, "_lat"}, 32'(busy), 32'd14);
        check({tag, "_stable"}, 32'(changes), 32'd0);
        check({tag, "_score"}, 32'(score_bcd), 32'(exp_score));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // Holds add_valid high until n requests have been accepted.
    task automatic add_n(input logic [7:0] v, input int n);
        int hs = 0;
        int cyc = 0;
        add_valid = 1'b1;
        add_value = v;
        while (hs < n && cyc < n * 16 + 50) begin
            if (add_ready) hs++;
            tick();
            cyc++;
        end
        add_valid = 1'b0;
        check("bulk_hs", 32'(hs), 32'(n));
        wait_ready("bulk");
    endtask

    initial begin
        int hs;
        int cyc;
        int last;
        Reset = 1'b0;
        clear = 1'b0;
        add_valid = 1'b0;
        add_value = 8'd0;

        tick();
        tick();
        Reset = 1'b1;
        check("rst_score", 32'(score_bcd), 32'h000000);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ready", 32'(add_ready), 32'd1);

        do_add("add255", 8'd255, 24'h000255, 1'b0);
        do_add("add255b", 8'd255, 24'h000510, 1'b0);
        do_add("add255c", 8'd255, 24'h000765, 1'b0);
        do_add("add234", 8'd234, 24'h000999, 1'b0);
        do_add("carry1", 8'd1, 24'h001000, 1'b0);
        do_add("add0", 8'd0, 24'h001000, 1'b0);

        // 1000 + 3917*255 = 999835, + 65 = 999900
        add_n(8'd255, 3917);
        check("bulk_score", 32'(score_bcd), 32'h999835);
        do_add("add65", 8'd65, 24'h999900, 1'b0);
        do_add("sat200", 8'd200, 24'h999999, 1'b1);
        do_add("sat5", 8'd5, 24'h999999, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_score", 32'(score_bcd), 32'h000000);
        check("clr_ovf", 32'(overflow), 32'd0);

        do_add("add50", 8'd50, 24'h000050, 1'b0);
        add_valid = 1'b1;
        add_value = 8'd100;
        tick();
        add_valid = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_score", 32'(score_bcd), 32'h000000);
        check("abort_ready", 32'(add_ready), 32'd1);
        repeat (20) tick();
        check("abort_late", 32'(score_bcd), 32'h000000);

        // clear beats a simultaneous handshake
        add_valid = 1'b1;
        add_value = 8'd33;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        add_valid = 1'b0;
        check("clrhs_ready", 32'(add_ready), 32'd1);
        repeat (20) tick();
        check("clrhs_score", 32'(score_bcd), 32'h000000);

        hs = 0;
        cyc = 0;
        last = 0;
        add_valid = 1'b1;
        add_value = 8'd7;
        while (hs < 3 && cyc < 100) begin
            if (add_ready) begin
                add_value = 8'd7;
                if (hs > 0) check("b2b_gap", 32'(cyc - last), 32'd15);
                last = cyc;
                hs++;
                tick();
                cyc++;
                add_value = 8'd9;
                if (hs == 3) add_valid = 1'b0;
            end else begin
                tick();
                cyc++;
            end
        end
        add_valid = 1'b0;
        check("b2b_hs", 32'(hs), 32'd3);
        wait_ready("b2b");
        check("b2b_score", 32'(score_bcd), 32'h000021);

        // Reset mid-operation, asserted together with clear
        add_valid = 1'b1;
        add_value = 8'd9;
        tick();
        add_valid = 1'b0;
        repeat (4) tick();
        Reset = 1'b0;
        clear = 1'b1;
        tick();
        Reset = 1'b1;
        clear = 1'b0;
        check("mrst_ready", 32'(add_ready), 32'd1);
        check("mrst_score", 32'(score_bcd), 32'h000000);
        repeat (20) tick();
        check("mrst_late", 32'(score_bcd), 32'h000000);
        check("mrst_ovf", 32'(overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
